cdce_serial_in: RTL
===================

Name: cdce_serial_in

Overview:
SPI readback receiver for the CDCE clock synthesizer, the capture side of the 32-bit serial command path. Once a read command has been written, the host pulses start_transaction. The block then asserts cs_n for exactly WIDTH clk cycles and samples miso LSB-first into a shift register. It presents the assembled word on parallel_output with a one-cycle data_valid strobe, and indicates idle/done status for the configuration sequencer.

Parameters:
WIDTH, 32, readback word length in bits (SPI frame length); legal range 8..32.
DEADTIME, 1, cycles cs_n is held high after a frame before a new start is accepted; minimum 1.

Ports:
clk  input  1  system/SPI bit clock; all logic on rising edge.
reset_n  input  1  asynchronous, active-low reset.
enable  input  1  qualifies start_transaction; does not abort a frame in progress.
start_transaction  input  1  level request; a frame starts when high with enable high in IDLE.
miso  input  1  serial data from the CDCE; sampled on the rising clk edge while in SHIFT.
cs_n  output  1  active-low chip select to the CDCE; registered.
parallel_output  output  WIDTH  last completed readback word; holds value between frames.
data_valid  output  1  one-cycle pulse when parallel_output is updated.
transaction_done  output  1  high when idle and no start is pending; low for the whole frame.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset, asynchronous: state=IDLE; cs_n=1; parallel_output=0; data_valid=0; transaction_done=0; busy=0; shift register=0; bit counter=WIDTH-1; deadtime counter=0.
- States: IDLE, SETUP, SHIFT, DELAY. Outputs are registered from the current state, so they follow state entry by one edge.
- IDLE: cs_n<=1; data_valid<=0; transaction_done<=~start_transaction. Go to SETUP if start_transaction & enable.
- SETUP, 1 cycle: clear shift register; bit counter<=WIDTH-1; cs_n<=0; transaction_done<=0. Go to SHIFT.
- SHIFT: each edge performs shreg <= {miso, shreg[WIDTH-1:1]} and decrements the counter. Stay in SHIFT while counter≠0. On the edge where counter==0, take the final sample and go to DELAY.
  - Result: the first sampled bit lands in bit 0 and the last in bit WIDTH-1.
- DELAY, DEADTIME cycles: cs_n<=1.
  - On the first DELAY edge: parallel_output<=shreg; data_valid<=1 for exactly one cycle.
  - transaction_done stays 0 through DELAY. Go to IDLE after DEADTIME cycles.
- Timing, with E0 = edge that samples start high in IDLE:
  - cs_n falls after E1 and rises after E1+WIDTH, so it is low for exactly WIDTH cycles.
  - miso is sampled at E2..E(WIDTH+1).
  - data_valid is high for the cycle following E(WIDTH+2).
- start_transaction in SETUP/SHIFT/DELAY is ignored, with no queuing. If start is still high when IDLE is re-entered, the next frame begins. Frame-to-frame cs_n high time is at least DEADTIME+1 cycles.
- enable falling mid-frame has no effect; the frame completes normally.
- Reset mid-frame: cs_n goes high immediately (asynchronously); the partial word is discarded; no data_valid is generated.
- parallel_output changes only on a data_valid cycle.

Test Plan:
1. Reset release, enable=1, start=0 -> cs_n=1, data_valid=0. transaction_done=0 during reset, then 1 one cycle after release with start low.
2. Pulse start one cycle, drive miso LSB-first with 0xA5C30F81 -> cs_n low exactly 32 cycles; miso sampled at E2..E33; parallel_output=0xA5C30F81 with a single data_valid pulse after E34; busy high from E1 to DELAY exit.
3. start=1 with enable=0 for 50 cycles -> cs_n stays 1, no data_valid, transaction_done=0 while start is held.
4. Hold start=1, enable=1 continuously; miso all-ones, then all-zeros -> back-to-back frames; outputs 0xFFFFFFFF then 0x00000000; cs_n high at least 2 cycles between frames (DEADTIME=1).
5. Assert reset_n low after 10 bits of a frame -> cs_n=1 immediately; parallel_output=0; no data_valid; the next frame captures its word correctly.
6. Re-pulse start during SHIFT and drop enable mid-frame -> no restart and no truncation; one 32-cycle frame; correct word delivered.

Source files
------------

// File: rtl/cdce_serial_in_if.sv
// Handshake and serial bus bundle between the configuration sequencer,
// the CDCE readback receiver and the CDCE SPI pins.
interface cdce_serial_in_if #(
    parameter int WIDTH = 32
);
    logic             enable;
    logic             start_transaction;
    logic             miso;
    logic             cs_n;
    logic [WIDTH-1:0] parallel_output;
    logic             data_valid;
    logic             transaction_done;
    logic             busy;

    modport master (
        output enable,
        output start_transaction,
        output miso,
        input  cs_n,
        input  parallel_output,
        input  data_valid,
        input  transaction_done,
        input  busy
    );

    modport slave (
        input  enable,
        input  start_transaction,
        input  miso,
        output cs_n,
        output parallel_output,
        output data_valid,
        output transaction_done,
        output busy
    );
endinterface

// File: rtl/cdce_serial_in.sv
// CDCE SPI readback receiver: frames cs_n for WIDTH clocks, captures miso
// LSB-first and publishes the word with a single-cycle data_valid strobe.
module cdce_serial_in #(
    parameter int WIDTH    = 32,
    parameter int DEADTIME = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    cdce_serial_in_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DW = $clog2(DEADTIME + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH - 1);
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEADTIME - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DELAY = 2'd3
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] shreg_r;
    logic [CW-1:0]    bit_cnt_r;
    logic [DW-1:0]    dead_cnt_r;
    logic             cs_n_r;
    logic [WIDTH-1:0] parallel_output_r;
    logic             data_valid_r;
    logic             transaction_done_r;
    logic             busy_r;

    // Frame sequencer; every output is registered from the current state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r            <= ST_IDLE;
            shreg_r            <= '0;
            bit_cnt_r          <= CNT_LAST;
            dead_cnt_r         <= '0;
            cs_n_r             <= 1'b1;
            parallel_output_r  <= '0;
            data_valid_r       <= 1'b0;
            transaction_done_r <= 1'b0;
            busy_r             <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cs_n_r             <= 1'b1;
                    data_valid_r       <= 1'b0;
                    busy_r             <= 1'b0;
                    transaction_done_r <= ~bus.start_transaction;
                    if (bus.start_transaction && bus.enable) begin
                        state_r <= ST_SETUP;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    shreg_r            <= '0;
                    bit_cnt_r          <= CNT_LAST;
                    cs_n_r             <= 1'b0;
                    data_valid_r       <= 1'b0;
                    transaction_done_r <= 1'b0;
                    busy_r             <= 1'b1;
                    state_r            <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    shreg_r            <= {bus.miso, shreg_r[WIDTH-1:1]};
                    bit_cnt_r          <= bit_cnt_r - CW'(1);
                    data_valid_r       <= 1'b0;
                    transaction_done_r <= 1'b0;
                    busy_r             <= 1'b1;
                    // Release cs_n on the last sample so it is low for exactly WIDTH clocks.
                    if (bit_cnt_r == CW'(0)) begin
                        cs_n_r     <= 1'b1;
                        dead_cnt_r <= DEAD_LAST;
                        state_r    <= ST_DELAY;
                    end else begin
                        cs_n_r     <= 1'b0;
                        state_r    <= ST_SHIFT;
                    end
                end
                ST_DELAY: begin
                    cs_n_r             <= 1'b1;
                    transaction_done_r <= 1'b0;
                    busy_r             <= 1'b1;
                    if (dead_cnt_r == DEAD_LAST) begin
                        parallel_output_r <= shreg_r;
                        data_valid_r      <= 1'b1;
                    end else begin
                        data_valid_r      <= 1'b0;
                    end
                    if (dead_cnt_r == DW'(0)) begin
                        state_r <= ST_IDLE;
                    end else begin
                        dead_cnt_r <= dead_cnt_r - DW'(1);
                        state_r    <= ST_DELAY;
                    end
                end
                default: begin
                    state_r            <= ST_IDLE;
                    cs_n_r             <= 1'b1;
                    data_valid_r       <= 1'b0;
                    transaction_done_r <= 1'b0;
                    busy_r             <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cs_n             = cs_n_r;
    assign bus.parallel_output  = parallel_output_r;
    assign bus.data_valid       = data_valid_r;
    assign bus.transaction_done = transaction_done_r;
    assign bus.busy             = busy_r;
endmodule
